// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: two-flop synchronizer, then a hold counter per bit.
// Define SWITCH_EDGE_PULSE_EN to add the per-bit switches_rise/switches_fall pulse outputs.
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic             switches_changed
`ifdef SWITCH_EDGE_PULSE_EN
  ,
  output logic [WIDTH-1:0] switches_rise,
  output logic [WIDTH-1:0] switches_fall
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] update;

  function automatic logic cnt_at_limit(input logic [CNT_W-1:0] c);
    return c == CNT_LAST;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous raw inputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= switches_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-bit hold counter; any agreement with the current output restarts it
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_p2;

    assign update[i] = (sync_p1[i] != switches[i]) && cnt_at_limit(cnt_p2);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_p2 <= '0;
      end else if ((sync_p1[i] == switches[i]) || update[i]) begin
        cnt_p2 <= '0;
      end else begin
        cnt_p2 <= cnt_p2 + CNT_W'(1);
      end
    end
  end

  // Stage p3: accepted value and change pulses, all straight from flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      switches         <= '0;
      switches_changed <= 1'b0;
    end else begin
      switches         <= (switches & ~update) | (sync_p1 & update);
      switches_changed <= |update;
    end
  end

`ifdef SWITCH_EDGE_PULSE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      switches_rise <= '0;
      switches_fall <= '0;
    end else begin
      switches_rise <= update & sync_p1;
      switches_fall <= update & ~sync_p1;
    end
  end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4, WIDTH=4, 10 ns clock.
// Edge-pulse outputs are checked when SWITCH_EDGE_PULSE_EN is defined.
module tb_switch_debouncer;
  localparam int WIDTH = 4;
  localparam int DC    = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] switches_raw = '0;
  logic [WIDTH-1:0] switches;
  logic             switches_changed;
`ifdef SWITCH_EDGE_PULSE_EN
  logic [WIDTH-1:0] switches_rise;
  logic [WIDTH-1:0] switches_fall;
`endif

  int vectors = 0;
  int miscompares = 0;

  switch_debouncer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
    .clock            (clock),
    .reset            (reset),
    .switches_raw     (switches_raw),
    .switches         (switches),
    .switches_changed (switches_changed)
`ifdef SWITCH_EDGE_PULSE_EN
    ,
    .switches_rise    (switches_rise),
    .switches_fall    (switches_fall)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sw, input logic ch,
                         input logic [3:0] rise, input logic [3:0] fall);
    chk({tag, ".sw"}, 32'(switches), 32'(sw));
    chk({tag, ".chg"}, 32'(switches_changed), 32'(ch));
`ifdef SWITCH_EDGE_PULSE_EN
    chk({tag, ".rise"}, 32'(switches_rise), 32'(rise));
    chk({tag, ".fall"}, 32'(switches_fall), 32'(fall));
`else
    if (rise !== fall) begin end
`endif
  endtask

  // Raw input already set by caller before the first edge; update lands on the 6th edge.
  task automatic debounce(input string tag, input logic [3:0] from, input logic [3:0] to);
    for (int i = 1; i <= DC + 1; i++) begin
      tick();
      chk_out(tag, from, 1'b0, 4'h0, 4'h0);
    end
    tick();
    chk_out({tag, ".upd"}, to, 1'b1, to & ~from, from & ~to);
    tick();
    chk_out({tag, ".post"}, to, 1'b0, 4'h0, 4'h0);
  endtask

  initial begin
    // reset held low with all raw inputs high for 100 ns
    reset = 1'b0;
    switches_raw = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("rst_hold", 4'h0, 1'b0, 4'h0, 4'h0);
    end
    switches_raw = 4'h0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_out("idle", 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk_out("idle", 4'h0, 1'b0, 4'h0, 4'h0);

    // clean single-bit rise, then fall back
    switches_raw = 4'h1;
    debounce("rise0", 4'h0, 4'h1);
    switches_raw = 4'h0;
    debounce("fall0", 4'h1, 4'h0);

    // bounce shorter than the debounce window, five times
    for (int r = 0; r < 5; r++) begin
      switches_raw = 4'h1;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk_out("glitch", 4'h0, 1'b0, 4'h0, 4'h0);
      end
      switches_raw = 4'h0;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk_out("glitch", 4'h0, 1'b0, 4'h0, 4'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("glitch_tail", 4'h0, 1'b0, 4'h0, 4'h0);
    end

    // two bits together, then mixed rise/fall transitions
    switches_raw = 4'hA;
    debounce("two_bits", 4'h0, 4'hA);
    switches_raw = 4'h1;
    debounce("a_to_1", 4'hA, 4'h1);
    switches_raw = 4'h2;
    debounce("1_to_2", 4'h1, 4'h2);

    // bits accepted on consecutive edges
    switches_raw = 4'h6;
    tick();
    chk_out("consec", 4'h2, 1'b0, 4'h0, 4'h0);
    switches_raw = 4'hE;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("consec", 4'h2, 1'b0, 4'h0, 4'h0);
    end
    tick();
    chk_out("consec.b2", 4'h6, 1'b1, 4'h4, 4'h0);
    tick();
    chk_out("consec.b3", 4'hE, 1'b1, 4'h8, 4'h0);
    tick();
    chk_out("consec.post", 4'hE, 1'b0, 4'h0, 4'h0);

    // asynchronous reset clears outputs without a clock edge
    reset = 1'b0;
    #1;
    chk_out("async_rst", 4'h0, 1'b0, 4'h0, 4'h0);
    switches_raw = 4'h0;
    tick();
    chk_out("async_rst.hold", 4'h0, 1'b0, 4'h0, 4'h0);
    reset = 1'b1;
    tick();

    // reset mid-count discards the partial count
    switches_raw = 4'h1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("midcount", 4'h0, 1'b0, 4'h0, 4'h0);
    end
    reset = 1'b0;
    #1;
    chk_out("midcount.rst", 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk_out("midcount.rst", 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk_out("midcount.rst", 4'h0, 1'b0, 4'h0, 4'h0);
    reset = 1'b1;
    debounce("after_rst", 4'h0, 4'h1);

    // raw already high at reset release goes through normal debounce
    reset = 1'b0;
    switches_raw = 4'hF;
    tick();
    tick();
    chk_out("prehigh.rst", 4'h0, 1'b0, 4'h0, 4'h0);
    reset = 1'b1;
    debounce("prehigh", 4'h0, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
